// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and sizing constants for serial_adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach WIDTH itself, so one bit beyond the index width.
    function automatic int cnt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - one-bit full adder cell used by serial_adder
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first; SERIAL_ADDER_OVF_EN adds signed overflow output ovf
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_bits(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic             load;
    logic             step;
    logic             last;
    logic             fa_s;
    logic             fa_co;

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    serial_fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Operands shift right so bit 0 always feeds the cell; sum fills from the MSB end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            carry_q <= fa_co;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the MSB step carry_q is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (step && last) begin
            cout_q <= fa_co;
            ovf_q  <= carry_q ^ fa_co;
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
        end else if (load) begin
            cout_q <= 1'b0;
        end else if (step && last) begin
            cout_q <= fa_co;
        end
    end
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int nvec = 0;
    int nerr = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives start for one accepted cycle; returns cycles from the start cycle to the done cycle.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, output int lat);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int dones;
    int busy_drop;
    logic [WIDTH-1:0] held;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_sum",  32'(sum),  32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h0F, 8'h01, 1'b0, lat);
        check("lat_0f01", 32'(lat),  32'd9);
        check("sum_0f01", 32'(sum),  32'h10);
        check("cout_0f01", 32'(cout), 32'h0);
        held = sum;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'h0);
        check("idle_busy",  32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        check("sum_hold",   32'(sum),  32'(held));

        run_op(8'hFF, 8'h01, 1'b0, lat);
        check("sum_ff01",  32'(sum),  32'h00);
        check("cout_ff01", 32'(cout), 32'h1);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf_ff01",  32'(ovf),  32'h0);
`endif
        @(negedge clk);

        run_op(8'h7F, 8'h00, 1'b1, lat);
        check("sum_7f00c",  32'(sum),  32'h80);
        check("cout_7f00c", 32'(cout), 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf_7f00c",  32'(ovf),  32'h1);
`endif
        @(negedge clk);

        run_op(8'hFF, 8'hFF, 1'b1, lat);
        check("sum_ffffc",  32'(sum),  32'hFF);
        check("cout_ffffc", 32'(cout), 32'h1);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf_ffffc",  32'(ovf),  32'h0);
`endif
        @(negedge clk);

        run_op(8'h80, 8'h80, 1'b0, lat);
        check("sum_8080",  32'(sum),  32'h00);
        check("cout_8080", 32'(cout), 32'h1);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf_8080",  32'(ovf),  32'h1);
`endif
        @(negedge clk);

        // start held high through RUN and into the DONE cycle
        a         = 8'h12;
        b         = 8'h34;
        cin       = 1'b0;
        start     = 1'b1;
        dones     = 0;
        busy_drop = 0;
        lat       = 0;
        @(posedge clk);
        @(negedge clk);
        while (!done && lat < 40) begin
            if (!busy) busy_drop++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("hold_lat",  32'(lat), 32'd8);
        check("hold_sum",  32'(sum), 32'h46);
        check("hold_busy", 32'(busy_drop), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_start_ignored", 32'(busy), 32'h0);
        start = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("extra_done", 32'(dones), 32'd0);

        // reset mid-RUN
        a     = 8'h55;
        b     = 8'h11;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_sum",  32'(sum),  32'h0);
        check("mid_rst_cout", 32'(cout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h03, 8'h04, 1'b0, lat);
        check("post_rst_lat", 32'(lat), 32'd9);
        check("post_rst_sum", 32'(sum), 32'h07);
        @(negedge clk);

        // operands changed after acceptance
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("chg_lat",  32'(lat),  32'd9);
        check("chg_sum",  32'(sum),  32'h03);
        check("chg_cout", 32'(cout), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, operand A; captured on accepted start.
REQ-006 The block SHALL have port b, input, WIDTH, operand B; captured on accepted start.
REQ-007 The block SHALL have port cin, input, 1, initial carry-in; captured on accepted start.
REQ-008 The block SHALL have port busy, output, 1, high while in RUN or DONE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking that sum/cout are valid.
REQ-010 The block SHALL have port sum, output, WIDTH, result A+B+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1, final carry-out.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 SHALL load a, b and cin into shift/carry registers, clear the bit counter, and go to RUN next cycle.
REQ-014 In RUN, each cycle SHALL add one bit pair, LSB first, through a one-bit full-adder cell, with carry held in a register between cycles.
REQ-015 Each RUN cycle SHALL shift the sum bit into the sum register from the MSB end and increment the counter.
REQ-016 After exactly WIDTH RUN cycles the FSM SHALL enter DONE; latency from accepted start to done SHALL be WIDTH+1 cycles.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle and cout SHALL equal the final carry; the FSM then returns to IDLE.
REQ-018 sum and cout SHALL hold their values after DONE until the next accepted start.
REQ-019 start SHALL be ignored while busy=1; a start asserted in the DONE cycle SHALL NOT be accepted.
REQ-020 Changes to a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-021 The carry SHALL wrap only into cout; sum SHALL never exceed WIDTH bits.
REQ-022 The counter SHALL be wide enough to count WIDTH without wrap ($clog2(WIDTH)+1 bits).

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, and clear the carry and counter, including mid-RUN.
REQ-024 After rst_n deasserts, the first accepted start SHALL behave as from a clean IDLE.

Configuration
REQ-025 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output ovf, 1 bit: signed overflow = carry into the MSB XOR final carry, valid with done and held like sum; reset value 0.
REQ-026 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-028 The one-bit adder SHALL be a separate sub-module serial_fa_cell (inputs a, b, ci; outputs s, co), instantiated once.

Verification
REQ-029 WIDTH=8, a=8'h0F, b=8'h01, cin=0, start -> done at cycle 9 after start, sum=8'h10, cout=0.
REQ-030 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; with OVF_EN ovf=0.
REQ-031 a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0; with OVF_EN ovf=1.
REQ-032 start held high through RUN, and start pulsed in the DONE cycle -> exactly one done per accepted start, busy never drops mid-operation.
REQ-033 rst_n pulsed low at RUN cycle 4 -> busy, done, sum, cout all 0 immediately; a following a=8'h03, b=8'h04 -> sum=8'h07.
REQ-034 Operands changed to 8'hAA/8'h55 one cycle after start of 8'h01+8'h02 -> sum=8'h03.
